// File: rtl/exec_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : exec_mul_seq
// Purpose  : Iterative shift-add multiply sequencer. Borrows the execute-stage
//            ALU (ADD operation) once per multiplier bit and returns the low
//            WIDTH bits of the product. Stalls the pipeline from request until
//            the response has been consumed.
// Options  : MUL_EARLY_EXIT_EN - finish as soon as no multiplier bits remain
//            (latency = 1 + index of the highest set bit of req_b). Undefined
//            by default, giving a fixed WIDTH-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module exec_mul_seq #(
  parameter int          WIDTH    = 16,
  parameter int          CNT_W    = 5,
  parameter logic [2:0]  ADD_OPER = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  // shared ALU interface
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_oper,
  output logic             alu_inva,
  output logic             alu_invb,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  // response channel
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  // pipeline hold
  output logic             stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic             in_idle;
  logic             in_run;
  logic             in_done;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] mplier_next;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);
  assign in_done = (state_q == ST_DONE);
  assign accept  = in_idle && req_valid;

  assign mplier_next = mplier_q >> 1;

  // Decide whether the current RUN cycle is the final accumulation step.
`ifdef MUL_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain; a zero multiplier therefore
  // spends exactly one cycle in RUN and leaves acc at 0.
  assign last_iter = (cnt_q == LAST_CNT) || (mplier_next == '0);
`else
  assign last_iter = (cnt_q == LAST_CNT);
`endif

  // Next-state and datapath update for the shift-add sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d    = '0;
          mcand_d  = req_a;
          mplier_d = req_b;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        // The ALU computes acc + mcand this cycle; keep it only for a set bit.
        acc_d    = mplier_q[0] ? alu_out : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // acc is held untouched here so resp_data stays stable until taken.
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle sequencer.
        state_d  = ST_IDLE;
        acc_d    = '0;
        mcand_d  = '0;
        mplier_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any product in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake and ALU-ownership outputs, decoded from registered state only
  // so they fall asynchronously with reset.
  always_comb begin
    req_ready  = in_idle;
    resp_valid = in_done;
    resp_data  = in_done ? acc_q : '0;
    alu_own    = in_run;
    alu_a      = in_run ? acc_q   : '0;
    alu_b      = in_run ? mcand_q : '0;
    alu_oper   = in_run ? ADD_OPER : 3'b000;
    alu_inva   = 1'b0;
    alu_invb   = 1'b0;
    alu_cin    = 1'b0;
  end

  // Hold the pipeline from the request cycle until the product is consumed.
  always_comb begin
    stall = accept || in_run || (in_done && !resp_ready);
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_mul_seq
// Purpose  : Directed self-checking bench for exec_mul_seq with a behavioural
//            ALU (ADD when ADD_OPER is driven, zero otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_mul_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_oper;
  logic             alu_inva;
  logic             alu_invb;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_out;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [WIDTH-1:0] resp_data;
  logic             stall;

  int total = 0;
  int bad   = 0;

  exec_mul_seq #(.WIDTH(16), .CNT_W(5), .ADD_OPER(3'b100)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_own    (alu_own),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_oper   (alu_oper),
    .alu_inva   (alu_inva),
    .alu_invb   (alu_invb),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: only the ADD encoding produces a sum.
  assign alu_out = (alu_oper == 3'b100) ? (alu_a + alu_b) : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until resp_valid, counting cycles and ALU-ownership cycles.
  task automatic wait_resp(output int lat, output int own);
    lat = 0;
    own = 0;
    while (!resp_valid && lat < 40) begin
      if (alu_own) own++;
      step();
      lat++;
    end
  endtask

  // Full transaction: accept, scramble inputs, measure latency, check result.
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int lat_full, input int lat_early);
    int lat, own, exp_lat;
`ifdef MUL_EARLY_EXIT_EN
    exp_lat = lat_early;
`else
    exp_lat = lat_full;
`endif
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    #1;
    chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    step();
    req_valid = 1'b0;
    req_a     = 16'hDEAD;
    req_b     = 16'hBEEF;
    wait_resp(lat, own);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_own"}, 32'(own), 32'(exp_lat));
    chk({tag, "_data"}, 32'(resp_data), 32'(exp));
    resp_ready = 1'b1;
    #1;
    chk({tag, "_stall_hs"}, 32'(stall), 32'd0);
    step();
    resp_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, req_ready, resp_valid, alu_own}, 32'b100);
  endtask

  initial begin
    int lat, own;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ctl", {26'd0, req_ready, resp_valid, alu_own, stall, alu_inva, alu_invb},
        32'b100000);
    chk("rst_alu", {alu_a, alu_b}, 32'd0);
    chk("rst_oper_cin", {28'd0, alu_oper, alu_cin}, 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // 3 x 5 with first-cycle ALU operand check
    req_valid = 1'b1; req_a = 16'd3; req_b = 16'd5;
    step();
    req_valid = 1'b0;
    chk("run_alu_a", 32'(alu_a), 32'd0);
    chk("run_alu_b", 32'(alu_b), 32'd3);
    chk("run_oper", {28'd0, alu_oper, alu_own}, {28'd0, 3'b100, 1'b1});
    wait_resp(lat, own);
`ifdef MUL_EARLY_EXIT_EN
    chk("m3x5_lat", 32'(lat), 32'd3);
    chk("m3x5_own", 32'(own), 32'd3);
`else
    chk("m3x5_lat", 32'(lat), 32'd16);
    chk("m3x5_own", 32'(own), 32'd16);
`endif
    chk("m3x5_data", 32'(resp_data), 32'h000F);

    // Hold resp_ready low for 3 cycles in DONE
    for (int i = 0; i < 3; i++) begin
      chk("hold_ctl", {28'd0, resp_valid, stall, req_ready, alu_own}, 32'b1100);
      chk("hold_data", 32'(resp_data), 32'h000F);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hold_exit", {30'd0, req_ready, resp_valid}, 32'b10);

    // Arithmetic corners
    do_mul("mffff", 16'hFFFF, 16'hFFFF, 16'h0001, 16, 16);
    do_mul("mneg3", 16'hFFFD, 16'h0007, 16'hFFEB, 16, 3);
    do_mul("mwrap", 16'h0100, 16'h0100, 16'h0000, 16, 9);
    do_mul("m5x2",  16'd5,    16'd2,    16'h000A, 16, 2);
    do_mul("m7x0",  16'd7,    16'd0,    16'h0000, 16, 1);

    // Reset pulsed in RUN cycle 7
    req_valid = 1'b1; req_a = 16'd1234; req_b = 16'hFFFF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_run", {30'd0, alu_own, stall}, 32'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst", {28'd0, alu_own, stall, resp_valid, req_ready}, 32'b0001);
    step();
    rst = 1'b0;
    step();
    chk("post_rst", {29'd0, alu_own, stall, req_ready}, 32'b001);
    do_mul("m2x9", 16'd2, 16'd9, 16'h0012, 16, 4);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h0010;
    step();
    req_a = 16'h00FF; req_b = 16'h0101;
    chk("b2b_acc1", {30'd0, req_ready, alu_own}, 32'b01);
    wait_resp(lat, own);
    chk("b2b_data1", 32'(resp_data), 32'h2340);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("b2b_gap", {29'd0, req_ready, resp_valid, stall}, 32'b101);
    step();
    req_valid = 1'b0;
    chk("b2b_acc2", {30'd0, req_ready, alu_own}, 32'b01);
    wait_resp(lat, own);
`ifdef MUL_EARLY_EXIT_EN
    chk("b2b_lat2", 32'(lat), 32'd9);
`else
    chk("b2b_lat2", 32'(lat), 32'd16);
`endif
    chk("b2b_data2", 32'(resp_data), 32'hFFFF);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("b2b_idle", {30'd0, req_ready, resp_valid}, 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
